usr_sequencer: RTL
==================

Name: usr_sequencer

Overview:
Command-driven controller for the universal shift register (modes 00 shift-left, 01 shift-right, 10 parallel-load, 11 hold). It accepts one operation at a time over a valid/ready handshake and drives the register's mode, serial-in and parallel-load data for the exact number of cycles required. It reports completion with a one-cycle done pulse. It sits between a host or test sequencer and one universal_shift_register instance.

Parameters:
WIDTH, 4, register width in bits
CNT_W, 3, width of the shift-count field (max shifts per command = 2^CNT_W-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 SHL, 01 SHR, 10 LOAD, 11 ROTL
cmd_count  input  CNT_W  number of shift cycles (ignored for LOAD)
cmd_fill  input  1  serial fill bit for SHL/SHR
cmd_data  input  WIDTH  parallel value for LOAD
abort  input  1  terminate the active operation
sr_q  input  WIDTH  current register contents (feedback for ROTL)
mode  output  2  register mode
sin  output  1  register serial input
par_out  output  WIDTH  register parallel-load data
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
done_aborted  output  1  qualifies done: operation was cut short

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Register semantics driven by this block:
  - SHL: q <= {q[W-2:0], sin}
  - SHR: q <= {sin, q[W-1:1]}
  - LOAD: q <= par_out
  - hold: q unchanged
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs except cmd_ready are registered.
- Reset values: state IDLE, mode=11, sin=0, par_out=0, busy=0, done=0, done_aborted=0, remaining=0. cmd_ready = (state==IDLE) && !reset, so it is 0 while reset is asserted.
- Accept: command is taken on an edge where cmd_valid && cmd_ready. Latch op, count, fill and data at that edge. cmd_valid while not ready is ignored; the command is not queued.
- LOAD:
  - Next state LOAD for exactly 1 cycle with mode=10 and par_out=cmd_data.
  - Then DONE.
- SHL/SHR/ROTL with count N>0:
  - SHIFT state for exactly N cycles. mode=00 (SHL, ROTL) or 01 (SHR).
  - sin = fill for SHL/SHR. For ROTL, sin = sr_q[WIDTH-1], sampled combinationally-registered each cycle so every edge rotates by one.
  - remaining decrements once per SHIFT cycle. Leave SHIFT when remaining reaches 1.
- Count N=0: go straight to DONE. No shift cycle is issued and mode stays 11.
- DONE: 1 cycle with done=1 and mode=11, then IDLE. Earliest next accept is the IDLE cycle after DONE.
- busy=1 in LOAD, SHIFT and DONE.
- mode=11 in IDLE and DONE, and after any abort.
- Abort:
  - Sampled only in LOAD or SHIFT. The current cycle's mode is already driven, so that edge's shift or load still happens.
  - Next state DONE with mode=11.
  - done_aborted=1 only if shift cycles would have remained after the current one. Abort in the final SHIFT cycle, or in LOAD, gives done_aborted=0.
  - Abort in IDLE or DONE is ignored.
- Reset mid-operation: next cycle is IDLE with all reset values. done does not pulse. Register contents are left as they are.
- Simultaneous reset and cmd_valid: reset wins and the command is not accepted.

Decomposition:
- Shared include usr_defs.vh holds:
  - mode encodings MODE_SHL=2'b00, MODE_SHR=2'b01, MODE_LOAD=2'b10, MODE_HOLD=2'b11
  - op encodings OP_SHL, OP_SHR, OP_LOAD, OP_ROTL
  - FSM state encodings
  The same file is usable by universal_shift_register and benches.
- No sub-module. The remaining-count down-counter stays inline in the FSM.

Test Plan:
- Reset, then LOAD 1010 -> mode=10 for exactly 1 cycle, sr_q=1010, done pulse 1 cycle, done_aborted=0, cmd_ready high the following cycle.
- From 0000, SHL count=3 fill=1 -> mode=00 for exactly 3 consecutive cycles, sr_q=0111, then done.
- From 1011, SHR count=2 fill=0 -> sr_q=0010. Then ROTL count=1 from 1001 -> sr_q=0011, with sin equal to 1 during the shift cycle.
- SHL count=0 -> done one cycle after accept, mode never leaves 11, sr_q unchanged.
- From 0000, SHL count=5 fill=1 with abort asserted in the 2nd SHIFT cycle -> exactly 2 shifts applied, sr_q=0011, done=1 with done_aborted=1. Abort held in the 5th cycle of a count=5 run -> done_aborted=0.
- Reset asserted in the 2nd cycle of a count=4 shift -> next cycle mode=11, busy=0, no done pulse. cmd_valid held during reset is not accepted.

Source files
------------

// File: rtl/usr_sequencer_pkg.sv
// rtl/usr_sequencer_pkg.sv - shared encodings for the universal shift register sequencer
//
// Holds the register mode encodings, the command op encodings and the
// sequencer FSM state type. Usable by the register itself and by benches.

package usr_sequencer_pkg;

    // Universal shift register mode inputs
    localparam logic [1:0] MODE_SHL  = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // Command op field
    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/usr_sequencer.sv
// rtl/usr_sequencer.sv - command-driven controller for a universal shift register
//
// Accepts one command at a time (cmd_valid/cmd_ready) and drives the
// register's mode, serial input and parallel-load data for exactly as many
// cycles as the command needs, then pulses done for one cycle.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready combinational)
//   cmd_op                00 SHL, 01 SHR, 10 LOAD, 11 ROTL
//   cmd_count             shift cycles for SHL/SHR/ROTL (0 = none)
//   cmd_fill              serial fill bit for SHL/SHR
//   cmd_data              parallel value for LOAD
//   abort                 cut the active LOAD/SHIFT short
//   sr_q                  register contents, feedback for ROTL
//   mode, sin, par_out    register control outputs
//   busy                  operation in progress (LOAD, SHIFT, DONE)
//   done, done_aborted    one-cycle completion pulse and its abort qualifier

module usr_sequencer
    import usr_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       mode,
    output logic             sin,
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             done,
    output logic             done_aborted
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [1:0]         op_q, op_d;
    logic               fill_q, fill_d;
    logic [1:0]         mode_q, mode_d;
    logic               sin_q, sin_d;
    logic               rotl_q, rotl_d;
    logic [WIDTH-1:0]   par_q, par_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        fill_d      = fill_q;
        mode_d      = MODE_HOLD;
        sin_d       = 1'b0;
        rotl_d      = 1'b0;
        par_d       = par_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    fill_d = cmd_fill;
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                        mode_d  = MODE_LOAD;
                        par_d   = cmd_data;
                    end else if (cmd_count == '0) begin
                        // Zero-length shift: report completion without touching the register
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        state_d     = ST_SHIFT;
                        remaining_d = cmd_count;
                        mode_d      = (cmd_op == OP_SHR) ? MODE_SHR : MODE_SHL;
                        sin_d       = (cmd_op == OP_ROTL) ? 1'b0 : cmd_fill;
                        rotl_d      = (cmd_op == OP_ROTL);
                    end
                end
            end

            ST_LOAD: begin
                // The load edge happens regardless of abort; abort here is never "early"
                state_d = ST_DONE;
                done_d  = 1'b1;
            end

            ST_SHIFT: begin
                remaining_d = remaining_q - CNT_W'(1);
                if (abort || remaining_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    remaining_d = '0;
                    aborted_d   = abort && (remaining_q > CNT_W'(1));
                end else begin
                    mode_d = (op_q == OP_SHR) ? MODE_SHR : MODE_SHL;
                    sin_d  = (op_q == OP_ROTL) ? 1'b0 : fill_q;
                    rotl_d = (op_q == OP_ROTL);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            op_q        <= OP_SHL;
            fill_q      <= 1'b0;
            mode_q      <= MODE_HOLD;
            sin_q       <= 1'b0;
            rotl_q      <= 1'b0;
            par_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            fill_q      <= fill_d;
            mode_q      <= mode_d;
            sin_q       <= sin_d;
            rotl_q      <= rotl_d;
            par_q       <= par_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE) && !reset;
    assign mode         = mode_q;
    // During ROTL the fed-back MSB must track the register every cycle so a
    // multi-cycle rotate moves by one position per edge; the select is registered.
    assign sin          = rotl_q ? sr_q[WIDTH-1] : sin_q;
    assign par_out      = par_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign done_aborted = aborted_q;

endmodule
